// File: rtl/fifo_tx_pkg.sv
// rtl/fifo_tx_pkg.sv - shared state encoding and counter sizing for the FIFO-to-UART-TX feeder
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    WAIT_DONE,
    GAP
  } state_t;

  localparam int SENT_CNT_WIDTH = 16;

  function automatic int timeout_cnt_width(input int busy_timeout);
    return (busy_timeout < 1) ? 1 : $clog2(busy_timeout + 1);
  endfunction

  function automatic int gap_cnt_width(input int gap_cycles);
    return (gap_cycles < 1) ? 1 : $clog2(gap_cycles + 1);
  endfunction

endpackage

// File: rtl/tx_wait_counter.sv
// rtl/tx_wait_counter.sv - up-counter with clear and terminal count against a loaded limit
module tx_wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  // Terminal one count early so the owner acts on the edge where the count would reach the limit.
  assign o_tc = (r_count == i_limit - WIDTH'(1));

endmodule

// File: rtl/fifo_tx_feeder.sv
// rtl/fifo_tx_feeder.sv - pops bytes from the result FIFO and hands them to the UART transmitter
module fifo_tx_feeder
  import fifo_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      fifo_empty,
  input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
  output logic                      fifo_r_inc,
  input  logic                      tx_busy,
  output logic                      tx_data_valid,
  output logic [DATA_WIDTH-1:0]     tx_p_data,
  output logic [SENT_CNT_WIDTH-1:0] sent_cnt,
  output logic                      tx_timeout
);

  localparam int TO_W  = timeout_cnt_width(BUSY_TIMEOUT);
  localparam int GAP_W = gap_cnt_width(GAP_CYCLES);
  localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(BUSY_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_CYCLES);

  state_t                    r_state;
  state_t                    w_next;
  logic [DATA_WIDTH-1:0]     r_hold;
  logic [SENT_CNT_WIDTH-1:0] r_sent_cnt;
  logic                      r_timeout;

  logic w_capture;
  logic w_frame_done;
  logic w_timeout_hit;
  logic w_to_clr;
  logic w_to_inc;
  logic w_to_tc;
  logic w_gap_clr;
  logic w_gap_inc;
  logic w_gap_tc;

  tx_wait_counter #(.WIDTH(TO_W)) u_busy_wait (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (w_to_clr),
    .i_inc   (w_to_inc),
    .i_limit (TO_LIMIT),
    .o_tc    (w_to_tc)
  );

  tx_wait_counter #(.WIDTH(GAP_W)) u_gap_wait (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (w_gap_clr),
    .i_inc   (w_gap_inc),
    .i_limit (GAP_LIMIT),
    .o_tc    (w_gap_tc)
  );

  always_comb begin
    w_next        = r_state;
    w_capture     = 1'b0;
    w_frame_done  = 1'b0;
    w_timeout_hit = 1'b0;
    w_to_clr      = 1'b1;
    w_to_inc      = 1'b0;
    w_gap_clr     = 1'b1;
    w_gap_inc     = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && !fifo_empty) begin
          w_capture = 1'b1;
          w_next    = POP;
        end
      end
      POP: w_next = LOAD;
      LOAD: begin
        // An already-busy transmitter wins over a coincident timeout.
        if (tx_busy) begin
          w_next = WAIT_DONE;
        end else if (w_to_tc) begin
          w_timeout_hit = 1'b1;
          w_next        = IDLE;
        end else begin
          w_to_clr = 1'b0;
          w_to_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          w_frame_done = 1'b1;
          w_next       = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (w_gap_tc) begin
          w_next = IDLE;
        end else begin
          w_gap_clr = 1'b0;
          w_gap_inc = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_sent_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_hold <= fifo_rd_data;
      end
      if (w_frame_done) begin
        r_sent_cnt <= r_sent_cnt + SENT_CNT_WIDTH'(1);
      end
      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign fifo_r_inc    = (r_state == POP);
  assign tx_data_valid = (r_state == LOAD);
  assign tx_p_data     = r_hold;
  assign sent_cnt      = r_sent_cnt;
  assign tx_timeout    = r_timeout;

endmodule

// File: tb/tb_fifo_tx_feeder.sv
// tb/tb_fifo_tx_feeder.sv - self-checking bench for fifo_tx_feeder with FIFO and UART TX models
module tb_fifo_tx_feeder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en0 = 1'b0;
  logic en1 = 1'b0;
  logic fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic tx_busy = 1'b0;

  logic inc0, inc1, val0, val1, to0, to1;
  logic [7:0] pd0, pd1;
  logic [15:0] sc0, sc1;

  fifo_tx_feeder #(.DATA_WIDTH(8), .GAP_CYCLES(0), .BUSY_TIMEOUT(16)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_r_inc(inc0), .tx_busy(tx_busy), .tx_data_valid(val0), .tx_p_data(pd0),
    .sent_cnt(sc0), .tx_timeout(to0)
  );

  fifo_tx_feeder #(.DATA_WIDTH(8), .GAP_CYCLES(5), .BUSY_TIMEOUT(16)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_r_inc(inc1), .tx_busy(tx_busy), .tx_data_valid(val1), .tx_p_data(pd1),
    .sent_cnt(sc1), .tx_timeout(to1)
  );

  always #5 clk = ~clk;

  // Both instances share the FIFO and UART models; only the selected one is ever enabled.
  bit sel = 1'b0;
  logic w_inc, w_val, w_to;
  logic [7:0] w_pd;
  logic [15:0] w_sc;
  assign w_inc = sel ? inc1 : inc0;
  assign w_val = sel ? val1 : val0;
  assign w_to  = sel ? to1 : to0;
  assign w_pd  = sel ? pd1 : pd0;
  assign w_sc  = sel ? sc1 : sc0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  bit flush_req = 1'b0;
  bit dead = 1'b0;
  bit rand_mode = 1'b0;

  logic [7:0] sent_q[$];
  int pop_q[$];
  int fall_q[$];
  int valid_q[$];
  int valid_hi = 0;
  int viol_cnt = 0;
  int u_wait = 0;
  int u_hold = 0;
  int delay_cur = 0;
  int hold_cur = 10;
  bit prev_inc = 1'b0;
  bit prev_val = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      tx_busy = 1'b0;
      u_hold = 0;
      u_wait = 0;
      if (flush_req) rd_ptr = wr_ptr;
    end else begin
      if (w_inc) begin
        if (fifo_empty || prev_inc) viol_cnt++;
        if (wr_ptr != rd_ptr) rd_ptr++;
        if (!prev_inc) pop_q.push_back(cyc);
      end
      if (w_val) begin
        valid_hi++;
        if (!prev_val) valid_q.push_back(cyc);
      end
      if (dead) begin
        tx_busy = 1'b0;
        u_wait = 0;
      end else if (u_hold > 0) begin
        u_hold--;
        if (u_hold == 0) begin
          tx_busy = 1'b0;
          fall_q.push_back(cyc + 1);
        end
      end else if (w_val && !tx_busy) begin
        if (u_wait < delay_cur) begin
          u_wait++;
        end else begin
          tx_busy = 1'b1;
          u_hold = hold_cur;
          u_wait = 0;
          sent_q.push_back(w_pd);
          if (rand_mode) begin
            delay_cur = $urandom_range(0, 3);
            hold_cur = $urandom_range(1, 8);
          end else begin
            delay_cur = 0;
            hold_cur = 10;
          end
        end
      end
    end
    prev_inc = w_inc;
    prev_val = w_val;
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_rd_data = mem[rd_ptr % 256];
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 256] = b;
    wr_ptr++;
  endtask

  task automatic do_reset();
    en0 = 1'b0;
    en1 = 1'b0;
    flush_req = 1'b1;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    flush_req = 1'b0;
    step(1);
  endtask

  task automatic wait_fall(input int target, input int budget, input string name);
    int k = 0;
    while (fall_q.size() < target && k < budget) begin
      step(1);
      k++;
    end
    checks++;
    if (fall_q.size() < target)
      begin errors++; $display("FAIL %s frames %0d exp %0d", name, fall_q.size(), target); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(2);
    for (int s = 0; s < 2; s++) begin
      logic ri, rv, rt;
      logic [7:0] rp;
      logic [15:0] rs;
      ri = s ? inc1 : inc0; rv = s ? val1 : val0; rt = s ? to1 : to0;
      rp = s ? pd1 : pd0;   rs = s ? sc1 : sc0;
      checks += 5;
      if (ri !== 1'b0) begin errors++; $display("FAIL reset_r_inc%0d got %0b exp 0", s, ri); end
      if (rv !== 1'b0) begin errors++; $display("FAIL reset_valid%0d got %0b exp 0", s, rv); end
      if (rt !== 1'b0) begin errors++; $display("FAIL reset_timeout%0d got %0b exp 0", s, rt); end
      if (rp !== 8'h00) begin errors++; $display("FAIL reset_p_data%0d got %0h exp 0", s, rp); end
      if (rs !== 16'h0) begin errors++; $display("FAIL reset_sent_cnt%0d got %0h exp 0", s, rs); end
    end
    rst = 1'b1;
    step(1);
  endtask

  task automatic test_single_byte();
    int bp, bs, bf, bv;
    sel = 1'b0;
    do_reset();
    bp = pop_q.size(); bs = sent_q.size(); bf = fall_q.size(); bv = valid_q.size();
    push(8'hA5);
    en0 = 1'b1;
    wait_fall(bf + 1, 100, "single_done");
    step(3);
    checks += 5;
    if (pop_q.size() - bp !== 1)
      begin errors++; $display("FAIL single_pops got %0d exp 1", pop_q.size() - bp); end
    if (sent_q.size() <= bs || sent_q[bs] !== 8'hA5)
      begin errors++; $display("FAIL single_byte got %0h exp a5", (sent_q.size() > bs) ? sent_q[bs] : 8'h00); end
    if (valid_q.size() <= bv || pop_q.size() <= bp || valid_q[bv] - pop_q[bp] !== 1)
      begin errors++; $display("FAIL single_latency got %0d exp 1", (valid_q.size() > bv && pop_q.size() > bp) ? valid_q[bv] - pop_q[bp] : -1); end
    if (w_sc !== 16'd1) begin errors++; $display("FAIL single_sent_cnt got %0d exp 1", w_sc); end
    if (!fifo_empty || wr_ptr != rd_ptr)
      begin errors++; $display("FAIL single_fifo_empty got %0d entries exp 0", wr_ptr - rd_ptr); end
  endtask

  task automatic test_burst_no_gap();
    int bp, bs, bf;
    sel = 1'b0;
    do_reset();
    bp = pop_q.size(); bs = sent_q.size(); bf = fall_q.size();
    for (int i = 1; i <= 4; i++) push(8'(i));
    en0 = 1'b1;
    wait_fall(bf + 4, 300, "burst_done");
    step(3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sent_q.size() <= bs + i || sent_q[bs + i] !== 8'(i + 1))
        begin errors++; $display("FAIL burst_byte%0d got %0h exp %0h", i, (sent_q.size() > bs + i) ? sent_q[bs + i] : 8'h00, i + 1); end
    end
    checks++;
    if (pop_q.size() - bp !== 4)
      begin errors++; $display("FAIL burst_pops got %0d exp 4", pop_q.size() - bp); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (pop_q.size() <= bp + i || pop_q[bp + i] - fall_q[bf + i - 1] !== 1)
        begin errors++; $display("FAIL burst_spacing%0d got %0d exp 1", i, (pop_q.size() > bp + i) ? pop_q[bp + i] - fall_q[bf + i - 1] : -1); end
    end
    checks += 2;
    if (w_sc !== 16'd4) begin errors++; $display("FAIL burst_sent_cnt got %0d exp 4", w_sc); end
    if (viol_cnt !== 0) begin errors++; $display("FAIL pop_protocol got %0d violations exp 0", viol_cnt); end
  endtask

  task automatic test_gap();
    int bp, bs, bf;
    logic [7:0] b0, b1;
    sel = 1'b1;
    do_reset();
    bp = pop_q.size(); bs = sent_q.size(); bf = fall_q.size();
    b0 = 8'($urandom); b1 = 8'($urandom);
    push(b0);
    push(b1);
    en1 = 1'b1;
    wait_fall(bf + 2, 200, "gap_done");
    step(3);
    checks += 4;
    if (pop_q.size() <= bp + 1 || pop_q[bp + 1] - fall_q[bf] !== 6)
      begin errors++; $display("FAIL gap_spacing got %0d exp 6", (pop_q.size() > bp + 1) ? pop_q[bp + 1] - fall_q[bf] : -1); end
    if (sent_q.size() <= bs + 1 || sent_q[bs] !== b0 || sent_q[bs + 1] !== b1)
      begin errors++; $display("FAIL gap_bytes got %0d sent exp %0h %0h", sent_q.size() - bs, b0, b1); end
    if (w_sc !== 16'd2) begin errors++; $display("FAIL gap_sent_cnt got %0d exp 2", w_sc); end
    if (pop_q.size() - bp !== 2) begin errors++; $display("FAIL gap_pops got %0d exp 2", pop_q.size() - bp); end
    en1 = 1'b0;
  endtask

  task automatic test_timeout();
    int bs, bf, bvh, k;
    logic [7:0] b;
    sel = 1'b0;
    do_reset();
    dead = 1'b1;
    bs = sent_q.size(); bf = fall_q.size(); bvh = valid_hi;
    push(8'h3C);
    en0 = 1'b1;
    k = 0;
    while (!w_to && k < 100) begin step(1); k++; end
    step(5);
    checks += 4;
    if (valid_hi - bvh !== 16) begin errors++; $display("FAIL timeout_valid_len got %0d exp 16", valid_hi - bvh); end
    if (w_to !== 1'b1) begin errors++; $display("FAIL timeout_flag got %0b exp 1", w_to); end
    if (w_sc !== 16'd0) begin errors++; $display("FAIL timeout_sent_cnt got %0d exp 0", w_sc); end
    if (sent_q.size() !== bs) begin errors++; $display("FAIL timeout_sent got %0d exp 0", sent_q.size() - bs); end
    dead = 1'b0;
    b = 8'($urandom);
    push(b);
    wait_fall(bf + 1, 100, "after_timeout_done");
    step(3);
    checks += 3;
    if (sent_q.size() <= bs || sent_q[bs] !== b)
      begin errors++; $display("FAIL after_timeout_byte got %0h exp %0h", (sent_q.size() > bs) ? sent_q[bs] : 8'h00, b); end
    if (w_sc !== 16'd1) begin errors++; $display("FAIL after_timeout_sent_cnt got %0d exp 1", w_sc); end
    if (w_to !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %0b exp 1", w_to); end
  endtask

  task automatic test_enable_reset();
    int bp, bs, bf, k;
    logic [7:0] b0;
    sel = 1'b0;
    do_reset();
    bp = pop_q.size(); bs = sent_q.size(); bf = fall_q.size();
    b0 = 8'($urandom);
    push(b0);
    for (int i = 0; i < 3; i++) push(8'($urandom));
    en0 = 1'b1;
    k = 0;
    while (!(tx_busy && !w_val) && k < 50) begin step(1); k++; end
    checks++;
    if (!(tx_busy && !w_val)) begin errors++; $display("FAIL reach_wait_done got busy %0b valid %0b exp 1 0", tx_busy, w_val); end
    en0 = 1'b0;
    wait_fall(bf + 1, 100, "en_off_done");
    step(30);
    checks += 4;
    if (pop_q.size() - bp !== 1) begin errors++; $display("FAIL en_off_pops got %0d exp 1", pop_q.size() - bp); end
    if (w_sc !== 16'd1) begin errors++; $display("FAIL en_off_sent_cnt got %0d exp 1", w_sc); end
    if (wr_ptr - rd_ptr !== 3) begin errors++; $display("FAIL en_off_fifo got %0d exp 3", wr_ptr - rd_ptr); end
    if (sent_q.size() <= bs || sent_q[bs] !== b0)
      begin errors++; $display("FAIL en_off_byte got %0h exp %0h", (sent_q.size() > bs) ? sent_q[bs] : 8'h00, b0); end
    dead = 1'b1;
    en0 = 1'b1;
    k = 0;
    while (!w_val && k < 50) begin step(1); k++; end
    checks++;
    if (w_val !== 1'b1) begin errors++; $display("FAIL reach_load got %0b exp 1", w_val); end
    en0 = 1'b0;
    rst = 1'b0;
    step(1);
    checks += 4;
    if (w_val !== 1'b0) begin errors++; $display("FAIL rst_load_valid got %0b exp 0", w_val); end
    if (w_sc !== 16'd0) begin errors++; $display("FAIL rst_load_sent_cnt got %0d exp 0", w_sc); end
    if (w_to !== 1'b0) begin errors++; $display("FAIL rst_load_timeout got %0b exp 0", w_to); end
    if (w_inc !== 1'b0) begin errors++; $display("FAIL rst_load_r_inc got %0b exp 0", w_inc); end
    rst = 1'b1;
    step(20);
    checks += 2;
    if (pop_q.size() - bp !== 2) begin errors++; $display("FAIL rst_load_pops got %0d exp 2", pop_q.size() - bp); end
    if (wr_ptr - rd_ptr !== 2) begin errors++; $display("FAIL rst_load_fifo got %0d exp 2", wr_ptr - rd_ptr); end
    dead = 1'b0;
  endtask

  task automatic test_wrap();
    int bf;
    sel = 1'b0;
    do_reset();
    bf = fall_q.size();
    force dut0.r_sent_cnt = 16'hFFFF;
    step(1);
    release dut0.r_sent_cnt;
    push(8'($urandom));
    en0 = 1'b1;
    wait_fall(bf + 1, 100, "wrap_done");
    step(3);
    checks++;
    if (w_sc !== 16'h0000) begin errors++; $display("FAIL wrap_sent_cnt got %0h exp 0", w_sc); end
  endtask

  task automatic test_random();
    for (int lane = 0; lane < 2; lane++) begin
      logic [7:0] exp_b[$];
      int bp, bs, bf, bad, gap, n;
      sel = lane[0];
      do_reset();
      rand_mode = 1'b1;
      gap = lane ? 5 : 0;
      n = 10;
      bp = pop_q.size(); bs = sent_q.size(); bf = fall_q.size();
      if (lane == 0) en0 = 1'b1; else en1 = 1'b1;
      while (exp_b.size() < n) begin
        int burst = $urandom_range(1, 3);
        for (int i = 0; i < burst && exp_b.size() < n; i++) begin
          logic [7:0] b = 8'($urandom);
          exp_b.push_back(b);
          push(b);
        end
        step($urandom_range(0, 40));
      end
      wait_fall(bf + n, 2000, "random_done");
      step(3);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (sent_q.size() <= bs + i || sent_q[bs + i] !== exp_b[i])
          begin errors++; $display("FAIL rand%0d_byte%0d got %0h exp %0h", lane, i, (sent_q.size() > bs + i) ? sent_q[bs + i] : 8'h00, exp_b[i]); end
      end
      bad = 0;
      for (int i = 1; i < n && bp + i < pop_q.size() && bf + i - 1 < fall_q.size(); i++)
        if (pop_q[bp + i] - fall_q[bf + i - 1] < gap + 1) bad++;
      checks += 4;
      if (bad !== 0) begin errors++; $display("FAIL rand%0d_spacing got %0d short gaps exp 0", lane, bad); end
      if (w_sc !== 16'(n)) begin errors++; $display("FAIL rand%0d_sent_cnt got %0d exp %0d", lane, w_sc, n); end
      if (w_to !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout got %0b exp 0", lane, w_to); end
      if (viol_cnt !== 0) begin errors++; $display("FAIL rand%0d_pop_protocol got %0d exp 0", lane, viol_cnt); end
      rand_mode = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst_no_gap();
    test_gap();
    test_timeout();
    test_enable_reset();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
